// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter; a small byte FIFO feeds an LSB-first serialiser on U_TX.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int FIFO_DEPTH = 4,
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [7:0]    IN_DATA,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [AW:0]   LEVEL,
    output logic          BUSY,
    output logic          U_TX
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int LW = AW + 1;
    localparam logic [BW-1:0] BMAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, rptr_q;
    logic [LW-1:0]   count_q, count_d;
    logic [BW-1:0]   bcnt_q;
    logic [2:0]      bidx_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic            push, pop, bit_end;

    assign IN_READY = !RST && (count_q != FULL);
    assign push     = IN_VALID && IN_READY;
    assign bit_end  = bcnt_q == BMAX;
    // A pop happens when idle or at the last cycle of a stop bit, giving gapless back-to-back frames
    assign pop      = (count_q != '0) && (state_q == IDLE || (state_q == STOP && bit_end));
    assign count_d  = count_q + LW'(push) - LW'(pop);
    assign LEVEL    = count_q;
    assign BUSY     = state_q != IDLE;
    assign U_TX     = tx_q;

    always_ff @(posedge CLK) begin
        if (push) mem_q[wptr_q] <= IN_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) begin
                rptr_q  <= rptr_q + 1'b1;
                shift_q <= mem_q[rptr_q];
            end
            bcnt_q <= (state_q == IDLE || bit_end) ? '0 : bcnt_q + 1'b1;
            case (state_q)
                IDLE: if (pop) begin
                    tx_q    <= 1'b0;
                    state_q <= START;
                end
                START: if (bit_end) begin
                    tx_q    <= shift_q[0];
                    shift_q <= shift_q >> 1;
                    bidx_q  <= '0;
                    state_q <= DATA;
                end
                DATA: if (bit_end) begin
                    if (bidx_q == 3'd7) begin
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                        bidx_q  <= bidx_q + 3'd1;
                    end
                end
                STOP: if (bit_end) begin
                    tx_q    <= !pop;
                    state_q <= pop ? START : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed stimulus against a frame-level reference model,
// plus an independent line decoder that recovers bytes from U_TX.
module tb_uart_tx_fifo;
    localparam int CPB = 4;
    localparam int D = 4;
    localparam int AW = 2;

    logic CLK = 1'b0, RST = 1'b1, IN_VALID = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic IN_READY, BUSY, U_TX;
    logic [AW:0] LEVEL;
    int tests = 0, fails = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(D), .AW(AW)) dut (
        .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .LEVEL(LEVEL), .BUSY(BUSY), .U_TX(U_TX)
    );

    always #5 CLK = ~CLK;

    // Reference model: queue of pending bytes plus the byte on the line and its cycle offset
    logic [7:0] mq[$], done_q[$], rx_q[$];
    logic [7:0] cur, db;
    bit act, dec_on;
    int t, cyc, ds;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int n);
        return n == 0 ? 1'b0 : n == 9 ? 1'b1 : b[n-1];
    endfunction

    task automatic step(input logic v, input logic [7:0] d, input logic r);
        int pre, off, n;
        bit pop;
        IN_VALID = v;
        IN_DATA = d;
        RST = r;
        @(posedge CLK);
        pre = mq.size();
        if (r) begin
            mq.delete();
            act = 0;
        end else begin
            pop = 0;
            if (act) begin
                t++;
                if (t == 10*CPB) begin
                    act = 0;
                    pop = pre > 0;
                end
            end else pop = pre > 0;
            if (pop) begin
                cur = mq.pop_front();
                act = 1;
                t = 0;
            end
            if (v && pre != D) mq.push_back(d);
            if (act && t == 10*CPB-1) done_q.push_back(cur);
        end
        #1;
        cyc++;
        check("tx", U_TX, act ? frame_bit(cur, t / CPB) : 1'b1);
        check("busy", BUSY, act);
        check("level", LEVEL, mq.size());
        check("ready", IN_READY, !r && mq.size() != D);
        if (r) dec_on = 0;
        else begin
            if (!dec_on && U_TX === 1'b0) begin
                dec_on = 1;
                ds = cyc;
            end
            if (dec_on) begin
                off = cyc - ds;
                if (off % CPB == CPB/2) begin
                    n = off / CPB;
                    if (n == 0) check("start_bit", U_TX, 0);
                    else if (n == 9) check("stop_bit", U_TX, 1);
                    else db[n-1] = U_TX;
                end
                if (off == 10*CPB-1) begin
                    rx_q.push_back(db);
                    dec_on = 0;
                end
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((act || mq.size() != 0) && n < 2000) begin
            step(0, 8'h00, 0);
            n++;
        end
        check("drain_idle", BUSY, 0);
        repeat (3) step(0, 8'h00, 0);
    endtask

    logic [7:0] bb[4] = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    int exp_lvl[4] = '{1, 1, 2, 3};
    logic [7:0] ob[6], fb[5], rb[3];
    logic [7:0] x, tmp;
    logic [9:0] bits;
    int nb, lows, busys, rises, base0, maxl, n, i, lvl, pop_cyc, acc_cyc, dens;
    logic pre_ready, prev_busy, r;

    initial begin
        repeat (3) step(0, 8'h00, 1);
        check("rst_tx", U_TX, 1);
        check("rst_busy", BUSY, 0);
        check("rst_level", LEVEL, 0);
        check("rst_ready", IN_READY, 0);

        lows = 0;
        busys = 0;
        repeat (1000) begin
            step(0, 8'($urandom), 0);
            lows += int'(!U_TX);
            busys += int'(BUSY);
        end
        check("idle_low", lows, 0);
        check("idle_busy", busys, 0);

        step(1, 8'h55, 0);
        check("sb_level_k", LEVEL, 1);
        bits = '0;
        nb = 0;
        for (int k = 1; k <= 12*CPB; k++) begin
            step(0, 8'h00, 0);
            if (k == 1) begin
                check("sb_fall", U_TX, 0);
                check("sb_busy_rise", BUSY, 1);
                check("sb_level_pop", LEVEL, 0);
            end
            nb += int'(BUSY);
            if ((k-1) % CPB == CPB/2 && (k-1) / CPB < 10) bits[(k-1)/CPB] = U_TX;
        end
        check("sb_bits", bits, 10'b1010101010);
        check("sb_busy_len", nb, 10*CPB);

        base0 = rx_q.size();
        nb = 0;
        rises = 0;
        prev_busy = BUSY;
        for (int k = 0; k < 4; k++) begin
            step(1, bb[k], 0);
            check("bb_level", LEVEL, exp_lvl[k]);
            nb += int'(BUSY);
            rises += int'(BUSY && !prev_busy);
            prev_busy = BUSY;
        end
        repeat (50*CPB) begin
            step(0, 8'h00, 0);
            nb += int'(BUSY);
            rises += int'(BUSY && !prev_busy);
            prev_busy = BUSY;
        end
        check("bb_busy_len", nb, 40*CPB);
        check("bb_contiguous", rises, 1);
        check("bb_frames", rx_q.size() - base0, 4);
        for (int k = 0; k < 4 && base0 + k < rx_q.size(); k++) check("bb_byte", rx_q[base0+k], bb[k]);

        base0 = rx_q.size();
        x = 8'($urandom);
        for (int k = 0; k < 6; k++) ob[k] = x + 8'(37*k);
        step(1, 8'hC3, 0);
        step(0, 8'h00, 0);
        step(0, 8'h00, 0);
        i = 0;
        n = 0;
        maxl = 0;
        while (i < 6 && n < 2000) begin
            pre_ready = IN_READY;
            step(1, ob[i], 0);
            if (pre_ready) i++;
            if (int'(LEVEL) > maxl) maxl = int'(LEVEL);
            if (LEVEL == D) check("ovf_ready_full", IN_READY, 0);
            n++;
        end
        check("ovf_all_accepted", i, 6);
        check("ovf_peak", maxl, D);
        drain();
        check("ovf_frames", rx_q.size() - base0, 7);
        if (rx_q.size() - base0 == 7) begin
            check("ovf_first", rx_q[base0], 8'hC3);
            for (int k = 0; k < 6; k++) check("ovf_byte", rx_q[base0+1+k], ob[k]);
        end

        base0 = rx_q.size();
        for (int k = 0; k < 5; k++) begin
            fb[k] = 8'($urandom);
            step(1, fb[k], 0);
        end
        check("fp_full", LEVEL, D);
        x = 8'($urandom);
        pop_cyc = -1;
        acc_cyc = -1;
        n = 0;
        while (acc_cyc < 0 && n < 200) begin
            pre_ready = IN_READY;
            lvl = int'(LEVEL);
            step(1, x, 0);
            n++;
            if (lvl == D && LEVEL == D-1 && pop_cyc < 0) begin
                pop_cyc = cyc;
                check("fp_ready_at_pop", pre_ready, 0);
            end
            if (pre_ready) begin
                acc_cyc = cyc;
                check("fp_level_after_acc", LEVEL, D);
            end
        end
        check("fp_accept_delay", acc_cyc - pop_cyc, 1);
        drain();
        check("fp_frames", rx_q.size() - base0, 6);
        if (rx_q.size() - base0 == 6) begin
            for (int k = 0; k < 5; k++) check("fp_byte", rx_q[base0+k], fb[k]);
            check("fp_late_byte", rx_q[base0+5], x);
        end

        for (int k = 0; k < 3; k++) begin
            rb[k] = 8'($urandom);
            step(1, rb[k], 0);
        end
        check("rm_queued", LEVEL, 2);
        n = 0;
        while (!(act && t == 4*CPB+1) && n < 200) begin
            step(0, 8'h00, 0);
            n++;
        end
        tmp = rb[0];
        check("rm_bit3", U_TX, tmp[3]);
        step(0, 8'h00, 1);
        check("rm_tx", U_TX, 1);
        check("rm_busy", BUSY, 0);
        check("rm_level", LEVEL, 0);
        lows = 0;
        busys = 0;
        repeat (100) begin
            step(0, 8'h00, 0);
            lows += int'(!U_TX);
            busys += int'(BUSY);
        end
        check("rm_quiet_low", lows, 0);
        check("rm_quiet_busy", busys, 0);

        dens = 5;
        for (int k = 0; k < 3000; k++) begin
            if (k % 500 == 0) dens = $urandom_range(1, 10);
            r = $urandom_range(0, 399) == 0;
            step($urandom_range(0, 9) < dens, 8'($urandom), r);
        end
        drain();

        check("rx_count", rx_q.size(), done_q.size());
        for (int k = 0; k < rx_q.size() && k < done_q.size(); k++) check("rx_byte", rx_q[k], done_q[k]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
